// File: rtl/subpel_pkg.sv
// subpel_pkg: shared constants, coefficient tables and state encoding for the
// HEVC-style luma sub-pixel interpolation engine.
`default_nettype none

package subpel_pkg;

    localparam int PIX_W     = 8;
    localparam int TAPS      = 8;
    localparam int BLK_DIM   = 8;
    localparam int IN_DIM    = 15;
    localparam int N_BLOCKS  = 5;
    localparam int N_BUSES   = 3;
    localparam int N_FILT    = 3;
    localparam int LOAD_ROWS = 15;
    localparam int DONE_CNT  = 23;

    localparam int ROW_W  = IN_DIM * PIX_W;
    localparam int OROW_W = BLK_DIM * PIX_W;
    localparam int BLK_W  = BLK_DIM * OROW_W;
    localparam int BUS_W  = N_BLOCKS * BLK_W;
    localparam int TMP_W  = IN_DIM * OROW_W;

    localparam logic [1:0] FILT_Q = 2'd0;
    localparam logic [1:0] FILT_H = 2'd1;
    localparam logic [1:0] FILT_T = 2'd2;

    localparam int COEF_Q [TAPS] = '{-1, 4, -10, 58, 17, -5, 1, 0};
    localparam int COEF_H [TAPS] = '{-1, 4, -11, 40, 40, -11, 4, -1};
    localparam int COEF_T [TAPS] = '{0, 1, -5, 17, 58, -10, 4, -1};

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_VERT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int coef(input logic [1:0] fsel, input int k);
        int c;
        c = 0;
        case (fsel)
            FILT_Q:  c = COEF_Q[k];
            FILT_H:  c = COEF_H[k];
            FILT_T:  c = COEF_T[k];
            default: c = 0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/subpel_fir8.sv
// subpel_fir8: one 8-tap Q/H/T filter lane with rounding and 0..255 clipping.
`default_nettype none

module subpel_fir8
    import subpel_pkg::*;
(
    input  logic [TAPS*PIX_W-1:0] taps,
    input  logic [1:0]            fsel,
    output logic [PIX_W-1:0]      result
);

    int acc;
    int rnd;

    always_comb begin
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + coef(fsel, k) * int'(taps[k*PIX_W +: PIX_W]);
        end
        rnd = (acc + 32) >>> 6;
        if (rnd < 0) begin
            result = '0;
        end else if (rnd > 255) begin
            result = 8'hFF;
        end else begin
            result = rnd[PIX_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/subpixel_interpolation.sv
// subpixel_interpolation: streams a 15x15 integer block and produces all 15
// fractional positions of the centre 8x8 block. Debug ports need SUBPIX_DEBUG_EN.
`default_nettype none

module subpixel_interpolation
    import subpel_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ROW_W-1:0]   in_row,
    output logic [3:0]         next_row,
    output logic [BUS_W-1:0]   out_A,
    output logic [BUS_W-1:0]   out_B,
    output logic [BUS_W-1:0]   out_C,
    output logic [7:0]         cnt,
    output logic [7:0]         sel,
    output logic               load_out,
    output logic [OROW_W-1:0]  fir_out_a,
    output logic [OROW_W-1:0]  fir_out_b,
    output logic [OROW_W-1:0]  fir_out_c,
    output logic [TMP_W-1:0]   temp_B,
    output logic [ROW_W-1:0]   currentPixels
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt_nxt;
    logic [2:0] vr;

    logic [PIX_W-1:0] row_buf [IN_DIM][IN_DIM];
    logic [PIX_W-1:0] temp_r  [N_BUSES][IN_DIM][BLK_DIM];
    logic [BUS_W-1:0] out_r   [N_BUSES];

    logic [PIX_W-1:0]      h_res [N_FILT][BLK_DIM];
    logic [PIX_W-1:0]      v_res [N_BUSES][N_FILT][BLK_DIM];
    logic [PIX_W-1:0]      p_res [N_BUSES][BLK_DIM];
    logic [TAPS*PIX_W-1:0] v_tap [N_BUSES][BLK_DIM];
    logic [TAPS*PIX_W-1:0] p_tap [BLK_DIM];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LOAD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        next_row  = 4'd0;
        sel       = 8'd0;
        load_out  = 1'b0;
        case (state)
            ST_LOAD: begin
                next_row = cnt[3:0];
                cnt_nxt  = cnt + 8'd1;
                if (cnt == 8'(LOAD_ROWS - 1)) begin
                    state_nxt = ST_VERT;
                end
            end
            ST_VERT: begin
                sel     = cnt - 8'(LOAD_ROWS);
                cnt_nxt = cnt + 8'd1;
                if (cnt == 8'(DONE_CNT - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                load_out = 1'b1;
            end
            default: begin
                state_nxt = ST_LOAD;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign vr = sel[2:0];

    // Horizontal lane x sees integer columns x..x+7 of the row being loaded.
    for (genvar x = 0; x < BLK_DIM; x++) begin : g_hcol
        for (genvar f = 0; f < N_FILT; f++) begin : g_hfilt
            subpel_fir8 u_fir (
                .taps   (in_row[x*PIX_W +: TAPS*PIX_W]),
                .fsel   (2'(f)),
                .result (h_res[f][x])
            );
        end
    end

    // Vertical windows: rows vr..vr+7 of each temp plane, and integer column x+3.
    always_comb begin
        for (int b = 0; b < N_BUSES; b++) begin
            for (int x = 0; x < BLK_DIM; x++) begin
                v_tap[b][x] = '0;
                for (int k = 0; k < TAPS; k++) begin
                    v_tap[b][x][k*PIX_W +: PIX_W] = temp_r[b][{1'b0, vr} + 4'(k)][x];
                end
            end
        end
        for (int x = 0; x < BLK_DIM; x++) begin
            p_tap[x] = '0;
            for (int k = 0; k < TAPS; k++) begin
                p_tap[x][k*PIX_W +: PIX_W] = row_buf[{1'b0, vr} + 4'(k)][x + 3];
            end
        end
    end

    for (genvar b = 0; b < N_BUSES; b++) begin : g_vbus
        for (genvar x = 0; x < BLK_DIM; x++) begin : g_vcol
            for (genvar f = 0; f < N_FILT; f++) begin : g_vfilt
                subpel_fir8 u_fir (
                    .taps   (v_tap[b][x]),
                    .fsel   (2'(f)),
                    .result (v_res[b][f][x])
                );
            end
            // Integer-column vertical filter: bus index doubles as Q/H/T select (d/h/n).
            subpel_fir8 u_pfir (
                .taps   (p_tap[x]),
                .fsel   (2'(b)),
                .result (p_res[b][x])
            );
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < IN_DIM; r++) begin
                for (int i = 0; i < IN_DIM; i++) begin
                    row_buf[r][i] <= '0;
                end
            end
            for (int b = 0; b < N_BUSES; b++) begin
                out_r[b] <= '0;
                for (int r = 0; r < IN_DIM; r++) begin
                    for (int x = 0; x < BLK_DIM; x++) begin
                        temp_r[b][r][x] <= '0;
                    end
                end
            end
        end else if (state == ST_LOAD) begin
            for (int i = 0; i < IN_DIM; i++) begin
                row_buf[cnt[3:0]][i] <= in_row[i*PIX_W +: PIX_W];
            end
            for (int b = 0; b < N_BUSES; b++) begin
                for (int x = 0; x < BLK_DIM; x++) begin
                    temp_r[b][cnt[3:0]][x] <= h_res[b][x];
                end
            end
        end else if (state == ST_VERT) begin
            for (int b = 0; b < N_BUSES; b++) begin
                for (int x = 0; x < BLK_DIM; x++) begin
                    out_r[b][0*BLK_W + OROW_W*int'(vr) + PIX_W*x +: PIX_W] <=
                        temp_r[b][{1'b0, vr} + 4'd3][x];
                    out_r[b][1*BLK_W + OROW_W*int'(vr) + PIX_W*x +: PIX_W] <= v_res[b][0][x];
                    out_r[b][2*BLK_W + OROW_W*int'(vr) + PIX_W*x +: PIX_W] <= v_res[b][1][x];
                    out_r[b][3*BLK_W + OROW_W*int'(vr) + PIX_W*x +: PIX_W] <= v_res[b][2][x];
                    out_r[b][4*BLK_W + OROW_W*int'(vr) + PIX_W*x +: PIX_W] <= p_res[b][x];
                end
            end
        end
    end

    assign out_A = out_r[0];
    assign out_B = out_r[1];
    assign out_C = out_r[2];

`ifdef SUBPIX_DEBUG_EN
    logic [OROW_W-1:0] fir_r [N_BUSES];
    logic [ROW_W-1:0]  cur_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_r <= '0;
            for (int b = 0; b < N_BUSES; b++) begin
                fir_r[b] <= '0;
            end
        end else if (state == ST_LOAD) begin
            cur_r <= in_row;
            for (int b = 0; b < N_BUSES; b++) begin
                for (int x = 0; x < BLK_DIM; x++) begin
                    fir_r[b][x*PIX_W +: PIX_W] <= h_res[b][x];
                end
            end
        end
    end

    always_comb begin
        temp_B = '0;
        for (int k = 0; k < IN_DIM; k++) begin
            for (int x = 0; x < BLK_DIM; x++) begin
                temp_B[OROW_W*k + PIX_W*x +: PIX_W] = temp_r[1][k][x];
            end
        end
    end

    assign fir_out_a     = fir_r[0];
    assign fir_out_b     = fir_r[1];
    assign fir_out_c     = fir_r[2];
    assign currentPixels = cur_r;
`else
    assign fir_out_a     = '0;
    assign fir_out_b     = '0;
    assign fir_out_c     = '0;
    assign temp_B        = '0;
    assign currentPixels = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_subpixel_interpolation.sv
// tb_subpixel_interpolation: directed table-driven bench for subpixel_interpolation.
`default_nettype none

module tb_subpixel_interpolation;

    logic          clk;
    logic          rst;
    logic [119:0]  in_row;
    logic [3:0]    next_row;
    logic [2559:0] out_A;
    logic [2559:0] out_B;
    logic [2559:0] out_C;
    logic [7:0]    cnt;
    logic [7:0]    sel;
    logic          load_out;
    logic [63:0]   fir_out_a;
    logic [63:0]   fir_out_b;
    logic [63:0]   fir_out_c;
    logic [959:0]  temp_B;
    logic [119:0]  currentPixels;

    int pattern;
    int n_pass;
    int n_total;

    subpixel_interpolation dut (
        .clk           (clk),
        .rst           (rst),
        .in_row        (in_row),
        .next_row      (next_row),
        .out_A         (out_A),
        .out_B         (out_B),
        .out_C         (out_C),
        .cnt           (cnt),
        .sel           (sel),
        .load_out      (load_out),
        .fir_out_a     (fir_out_a),
        .fir_out_b     (fir_out_b),
        .fir_out_c     (fir_out_c),
        .temp_B        (temp_B),
        .currentPixels (currentPixels)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Patterns: 0 flat 0x80, 1 ramp 10*col, 2 ramp 10*row, 3 spike col4, 4 spike col5.
    function automatic logic [119:0] make_row(input int p, input logic [3:0] r);
        logic [119:0] v;
        int val;
        v = '0;
        for (int i = 0; i < 15; i++) begin
            case (p)
                0:       val = 128;
                1:       val = 10 * i;
                2:       val = 10 * int'(r);
                3:       val = (i == 4) ? 255 : 0;
                4:       val = (i == 5) ? 255 : 0;
                default: val = 0;
            endcase
            v[8*i +: 8] = 8'(val);
        end
        return v;
    endfunction

    always_comb in_row = make_row(pattern, next_row);

    function automatic int bus_byte(input int bus, input int blk, input int r, input int x);
        logic [2559:0] v;
        v = (bus == 0) ? out_A : (bus == 1) ? out_B : out_C;
        return int'(v[512*blk + 64*r + 8*x +: 8]);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        int pat;
        int bus;
        int blk;
        int r;
        int x;
        int exp;
    } vec_t;

    localparam int N_VEC = 26;
    vec_t vecs [N_VEC];

    task automatic check_table(input int p);
        for (int i = 0; i < N_VEC; i++) begin
            if (vecs[i].pat == p) begin
                check($sformatf("pat%0d bus%0d blk%0d r%0d x%0d", p, vecs[i].bus,
                                vecs[i].blk, vecs[i].r, vecs[i].x),
                      bus_byte(vecs[i].bus, vecs[i].blk, vecs[i].r, vecs[i].x),
                      vecs[i].exp);
            end
        end
    endtask

    task automatic run_seq(input int p, output int edges);
        pattern = p;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        edges = 0;
        while (!load_out && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        int edges;
        int bad;
        int n;

        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{0, 0, 0, 0, 0, 128};
        vecs[1]  = '{0, 1, 2, 3, 5, 128};
        vecs[2]  = '{0, 2, 4, 7, 7, 128};
        vecs[3]  = '{1, 0, 0, 0, 0, 32};
        vecs[4]  = '{1, 0, 1, 2, 3, 62};
        vecs[5]  = '{1, 1, 2, 5, 7, 105};
        vecs[6]  = '{1, 2, 3, 7, 1, 48};
        vecs[7]  = '{1, 0, 4, 0, 2, 50};
        vecs[8]  = '{1, 1, 4, 4, 0, 30};
        vecs[9]  = '{1, 2, 4, 7, 7, 100};
        vecs[10] = '{2, 0, 0, 0, 0, 30};
        vecs[11] = '{2, 1, 0, 7, 4, 100};
        vecs[12] = '{2, 2, 0, 3, 7, 60};
        vecs[13] = '{2, 0, 4, 0, 0, 32};
        vecs[14] = '{2, 1, 4, 2, 5, 55};
        vecs[15] = '{2, 2, 4, 7, 3, 108};
        vecs[16] = '{2, 0, 1, 1, 0, 42};
        vecs[17] = '{2, 0, 2, 1, 0, 45};
        vecs[18] = '{2, 2, 3, 4, 6, 78};
        vecs[19] = '{3, 0, 0, 0, 0, 68};
        vecs[20] = '{3, 0, 0, 5, 1, 231};
        vecs[21] = '{3, 0, 0, 2, 3, 16};
        vecs[22] = '{3, 0, 4, 0, 1, 255};
        vecs[23] = '{3, 0, 4, 0, 0, 0};
        vecs[24] = '{4, 0, 0, 0, 0, 0};
        vecs[25] = '{4, 0, 0, 0, 1, 68};

        // Reset state
        pattern = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cnt", int'(cnt), 0);
        check("reset next_row", int'(next_row), 0);
        check("reset sel", int'(sel), 0);
        check("reset load_out", int'(load_out), 0);
        check("reset out_A nonzero", int'(|out_A), 0);

        // Flat image, observing the row request and vertical row sequence
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("next_row step %0d", i), int'(next_row), i);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("sel step %0d", i), int'(sel), i);
            check($sformatf("next_row vert %0d", i), int'(next_row), 0);
            @(negedge clk);
        end
        check("flat load_out", int'(load_out), 1);
        check("flat cnt", int'(cnt), 23);
        bad = 0;
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < 5; j++) begin
                for (int r = 0; r < 8; r++) begin
                    for (int x = 0; x < 8; x++) begin
                        if (bus_byte(b, j, r, x) != 128) bad++;
                    end
                end
            end
        end
        check("flat bad bytes", bad, 0);
        check_table(0);

        // Ramps and clipping spikes
        run_seq(1, edges);
        check("hramp latency", edges, 23);
        check_table(1);

        run_seq(3, edges);
        check("spike4 latency", edges, 23);
        check_table(3);
`ifdef SUBPIX_DEBUG_EN
        check("spike4 fir_out_a byte0", int'(fir_out_a[7:0]), 68);
        check("spike4 temp_B row0 byte0", int'(temp_B[7:0]), 159);
        check("spike4 currentPixels col4", int'(currentPixels[39:32]), 255);
`else
        check("fir_out_a tied", int'(|fir_out_a), 0);
        check("temp_B tied", int'(|temp_B), 0);
`endif

        run_seq(4, edges);
        check("spike5 latency", edges, 23);
        check_table(4);

        // Outputs hold in DONE
        repeat (5) @(posedge clk);
        #1;
        check("hold cnt", int'(cnt), 23);
        check("hold load_out", int'(load_out), 1);
        check("hold sel", int'(sel), 0);
        check("hold data", bus_byte(0, 0, 0, 1), 68);

        // Reset dropped mid-sequence, then a full vertical-ramp run
        pattern = 2;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (cnt != 8'd10 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("mid reach cnt10", int'(cnt), 10);
        #2;
        rst = 1'b0;
        #1;
        check("mid cnt cleared", int'(cnt), 0);
        check("mid next_row cleared", int'(next_row), 0);
        check("mid load_out", int'(load_out), 0);
        check("mid out_B cleared", int'(|out_B), 0);
        @(posedge clk);
        #1;
        check("mid held cnt", int'(cnt), 0);
        run_seq(2, edges);
        check("vramp latency", edges, 23);
        check_table(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/subpixel_interpolation.md
# subpixel_interpolation

Luma sub-pixel interpolation engine for HEVC-style motion compensation. It streams a 15×15 block of 8-bit integer pixels one row per cycle and applies the 8-tap quarter-, half- and three-quarter-pel filters horizontally, vertically and in two dimensions. It delivers all 15 fractional positions of the centre 8×8 block as wide parallel buses. It sits between the reference-row fetch (addressed by `next_row`) and the prediction consumer, which samples outputs on `load_out`.

## Interface
- `PIX_W`, 8: pixel width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in_row`  in  120  integer row; pixel column i at `[8i+7:8i]`.
- `next_row`  out  4  row index requested; `in_row` must be that row combinationally.
- `out_A`/`out_B`/`out_C`  out  2560 each  five 8×8 blocks; block j at `[512j+511:512j]`, row r at `+64r`, column x at byte x.
- `cnt`  out  8  sequence counter.
- `sel`  out  8  vertical output row, 0 outside vertical phase.
- `load_out`  out  1  all outputs valid.
- `fir_out_a`/`fir_out_b`/`fir_out_c`  out  64  debug: last horizontal row result.
- `temp_B`  out  960  debug: 15 horizontal half-pel rows, row k at `[64k+63:64k]`.
- `currentPixels`  out  120  debug: last captured row.

## Operation
- Filters: Q = [-1,4,-10,58,17,-5,1,0], H = [-1,4,-11,40,40,-11,4,-1], T = [0,1,-5,17,58,-10,4,-1].
- Output x uses taps on inputs x..x+7. Result = clip((Σ+32)>>>6, 0, 255), with signed ≥16-bit accumulation.
- Horizontal stage: row k gives A=Q, B=H, C=T rows, each stored as `temp_X` row k (8-bit clipped).
- Vertical filters run on the 8-bit `temp_X` values. This deliberately simplifies the standard's high-precision intermediate.
- Block map per bus X∈{A,B,C}, each output row r:
  - block0 = temp_X row r+3 (a/b/c).
  - block1 = Q over temp_X rows r..r+7.
  - block2 = H over the same rows.
  - block3 = T over the same rows (e/f/g, i/j/k, p/q/r).
  - block4 = vertical filter on integer pixel columns over rows r..r+7, using Q for A (d), H for B (h), T for C (n).
- States:
  - LOAD: cnt 0–14, next_row=cnt.
  - VERT: cnt 15–22, sel=cnt-15, next_row=0.
  - DONE: cnt=23 saturates, load_out=1.
- Outputs hold until reset.

## Timing
- Reset: every output and register is 0, next_row=0, state LOAD.
- LOAD edge at cnt=k:
  - row buffer[k] and currentPixels ← in_row.
  - temp_X row k ← horizontal results.
  - fir_out_* ← same results.
  - cnt++.
- VERT edge at sel=r: row r of all five blocks of all three buses written; cnt++.
- load_out rises on the edge where row 7 is written, the 23rd edge after reset release.
- Reset mid-sequence clears everything immediately; after release, the sequence restarts at row 0.

## Configuration
- `SUBPIX_DEBUG_EN`:
  - Defined: `fir_out_*`, `temp_B` and `currentPixels` are driven as above.
  - Undefined: these ports are tied to 0 and their registers are removed, except storage the datapath needs.
- Functional outputs are identical either way.

## Structure
- Package `subpel_pkg` holds:
  - coefficient arrays Q/H/T;
  - PIX_W, block/row/column counts (8, 15);
  - state enum;
  - the LOAD_ROWS=15 and DONE_CNT=23 constants.
- Sub-module `subpel_fir8`:
  - inputs: eight 8-bit taps plus 2-bit filter select;
  - output: rounded and clipped 8-bit result;
  - instantiated per lane for the horizontal and vertical stages.

## Test plan
- Reset: hold rst=0 → all outputs 0, next_row=0. Release → next_row counts 0..14 on successive cycles.
- Flat image, all pixels 0x80 → at load_out, every byte of out_A/B/C = 0x80.
- Horizontal ramp, pixel(r,i)=10i:
  - every row of blocks 0–3: A=10x+32, B=10x+35, C=10x+38;
  - block4 on every bus = 10x+30.
- Vertical ramp, pixel(r,i)=10r:
  - block0 on all buses = 10r+30;
  - block4: A=10r+32, B=10r+35, C=10r+38.
- Clipping: single 255 at column 4, rest 0 → fir_out_a byte0 = 68 (17·255). Spike at column 5 → fir_out_a byte0 = 0 (negative sum clipped).
- Drop rst at cnt=10 → immediate clear, load_out stays 0. After release, a full 23-cycle sequence completes with correct data.
